// File: rtl/fault_blink_pkg.sv
// Shared types and helpers for the fault blink encoder: sequencer states,
// counter width and the round-robin channel search.
package fault_blink_pkg;

  typedef enum logic [1:0] {IDLE, ON, OFF, GAP} state_t;

  localparam int CNT_W     = 8;
  localparam int MAX_CH    = 16;
  localparam int MAX_IDX_W = 4;

  typedef struct packed {
    logic                 found;
    logic [MAX_IDX_W-1:0] idx;
  } sel_t;

  // First set flag scanning upward from cur+1 and wrapping; cur itself is
  // visited last so a lone flag keeps being selected.
  function automatic sel_t next_set_idx(input logic [MAX_CH-1:0]    flags,
                                        input logic [MAX_IDX_W-1:0] cur,
                                        input int                   num_ch);
    sel_t r;
    int   j;
    r = '0;
    for (int k = 1; k <= MAX_CH; k++) begin
      if (k <= num_ch && !r.found) begin
        j = int'(cur) + k;
        if (j >= num_ch) j = j - num_ch;
        if (flags[j]) begin
          r.found = 1'b1;
          r.idx   = MAX_IDX_W'(j);
        end
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/fault_flag_bank.sv
// Sticky error flags with first-fault capture; with FAULT_CNT_EN defined it
// also keeps saturating per-channel event counters and a registered read port.
module fault_flag_bank
  import fault_blink_pkg::*;
#(
  parameter  int NUM_CH = 6,
  localparam int IDX_W  = $clog2(NUM_CH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NUM_CH-1:0] err_in,
  input  logic [NUM_CH-1:0] clr_mask,
  output logic [NUM_CH-1:0] flags,
  output logic [NUM_CH-1:0] flags_nxt,
  output logic [IDX_W-1:0]  first_idx,
  output logic              first_vld
`ifdef FAULT_CNT_EN
  ,
  input  logic [IDX_W-1:0]  cnt_sel,
  output logic [CNT_W-1:0]  cnt
`endif
);

  logic [IDX_W-1:0] low_idx;

  // Set wins over clear in the same cycle.
  assign flags_nxt = (flags & ~clr_mask) | err_in;

  always_comb begin
    low_idx = '0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (err_in[i]) low_idx = IDX_W'(i);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      flags     <= '0;
      first_vld <= 1'b0;
      first_idx <= '0;
    end else begin
      flags <= flags_nxt;
      if (!first_vld && |err_in) begin
        first_vld <= 1'b1;
        first_idx <= low_idx;
      end else if (first_vld && |clr_mask && flags_nxt == '0) begin
        first_vld <= 1'b0;
      end
    end
  end

`ifdef FAULT_CNT_EN
  localparam logic [CNT_W-1:0] CNT_ONE = 1;

  logic [CNT_W-1:0] ev_cnt [NUM_CH];

  // Clear wins over increment; counters stick at all-ones.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_CH; i++) ev_cnt[i] <= '0;
      cnt <= '0;
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        if (clr_mask[i])                        ev_cnt[i] <= '0;
        else if (err_in[i] && ev_cnt[i] != '1)  ev_cnt[i] <= ev_cnt[i] + CNT_ONE;
      end
      cnt <= (int'(cnt_sel) < NUM_CH) ? ev_cnt[cnt_sel] : '0;
    end
  end
`endif

endmodule

// File: rtl/fault_blink_encoder.sv
// Round-robin blink-code LED driver for sticky error flags: tick divider plus
// IDLE/ON/OFF/GAP sequencer. Define FAULT_CNT_EN to add per-channel counters.
module fault_blink_encoder
  import fault_blink_pkg::*;
#(
  parameter  int NUM_CH    = 6,
  parameter  int DIV       = 2000,
  parameter  int ON_TICKS  = 150,
  parameter  int OFF_TICKS = 150,
  parameter  int GAP_TICKS = 1000,
  localparam int IDX_W     = $clog2(NUM_CH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ena,
  input  logic [NUM_CH-1:0] err_in,
  input  logic [NUM_CH-1:0] clr_mask,
  output logic [NUM_CH-1:0] flags,
  output logic [IDX_W-1:0]  first_idx,
  output logic              first_vld,
  output logic              led
`ifdef FAULT_CNT_EN
  ,
  input  logic [IDX_W-1:0]  cnt_sel,
  output logic [CNT_W-1:0]  cnt
`endif
);

  localparam int TMAX   = (ON_TICKS > OFF_TICKS)
                          ? ((ON_TICKS  > GAP_TICKS) ? ON_TICKS  : GAP_TICKS)
                          : ((OFF_TICKS > GAP_TICKS) ? OFF_TICKS : GAP_TICKS);
  localparam int TMR_W  = $clog2(TMAX + 1);
  localparam int TCNT_W = (DIV > 1) ? $clog2(DIV) : 1;

  localparam logic [TMR_W-1:0]  T_ON     = TMR_W'(ON_TICKS - 1);
  localparam logic [TMR_W-1:0]  T_OFF    = TMR_W'(OFF_TICKS - 1);
  localparam logic [TMR_W-1:0]  T_GAP    = TMR_W'(GAP_TICKS - 1);
  localparam logic [TMR_W-1:0]  T_ONE    = 1;
  localparam logic [TCNT_W-1:0] TCNT_ONE = 1;
  localparam logic [IDX_W:0]    P_ONE    = 1;

  logic [NUM_CH-1:0] flags_nxt;
  logic [TCNT_W-1:0] tcnt;
  logic              tick;
  state_t            state, state_n;
  logic [IDX_W-1:0]  cur, cur_n, sel_idx;
  logic [IDX_W:0]    pulses, pulses_n;
  logic [TMR_W-1:0]  timer, timer_n;
  sel_t              sel;
  logic              abort;

  fault_flag_bank #(.NUM_CH(NUM_CH)) u_bank (
    .clk       (clk),
    .rst       (rst),
    .err_in    (err_in),
    .clr_mask  (clr_mask),
    .flags     (flags),
    .flags_nxt (flags_nxt),
    .first_idx (first_idx),
    .first_vld (first_vld)
`ifdef FAULT_CNT_EN
    ,
    .cnt_sel   (cnt_sel),
    .cnt       (cnt)
`endif
  );

  assign tick    = (tcnt == TCNT_W'(DIV - 1));
  assign sel     = next_set_idx(MAX_CH'(flags), MAX_IDX_W'(cur), NUM_CH);
  assign sel_idx = sel.idx[IDX_W-1:0];
  // Looking at next-cycle flags lets a clear drop the LED one clk after clr_mask.
  assign abort   = !ena || ((state != IDLE) && !flags_nxt[cur]);

  always_comb begin
    state_n  = state;
    cur_n    = cur;
    pulses_n = pulses;
    timer_n  = timer;
    if (abort) begin
      state_n = IDLE;
    end else if (tick) begin
      case (state)
        IDLE, GAP: begin
          if (state == IDLE || timer == '0) begin
            if (sel.found) begin
              cur_n    = sel_idx;
              pulses_n = {1'b0, sel_idx} + P_ONE;
              timer_n  = T_ON;
              state_n  = ON;
            end else begin
              state_n  = IDLE;
            end
          end else begin
            timer_n = timer - T_ONE;
          end
        end
        ON: begin
          if (timer == '0) begin
            pulses_n = pulses - P_ONE;
            timer_n  = T_OFF;
            state_n  = OFF;
          end else begin
            timer_n = timer - T_ONE;
          end
        end
        OFF: begin
          if (timer == '0) begin
            if (pulses != '0) begin
              timer_n = T_ON;
              state_n = ON;
            end else begin
              timer_n = T_GAP;
              state_n = GAP;
            end
          end else begin
            timer_n = timer - T_ONE;
          end
        end
        default: state_n = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tcnt   <= '0;
      state  <= IDLE;
      cur    <= IDX_W'(NUM_CH - 1);
      pulses <= '0;
      timer  <= '0;
      led    <= 1'b0;
    end else begin
      tcnt   <= tick ? '0 : tcnt + TCNT_ONE;
      state  <= state_n;
      cur    <= cur_n;
      pulses <= pulses_n;
      timer  <= timer_n;
      led    <= (state_n == ON) && ena;
    end
  end

endmodule

// File: tb/tb_fault_blink_encoder.sv
// Self-checking bench for fault_blink_encoder: flag table, LED run-length
// scoreboard, reset/clear/enable corner sequences and optional counters.
module tb_fault_blink_encoder;

  localparam int NUM_CH = 6;
  localparam int DIV    = 4;
  localparam int ON_T   = 2;
  localparam int OFF_T  = 2;
  localparam int GAP_T  = 6;
  localparam int PH_ON  = ON_T * DIV;
  localparam int PH_OFF = OFF_T * DIV;
  localparam int PH_GAP = GAP_T * DIV;

  logic        clk = 1'b0;
  logic        rst;
  logic        ena;
  logic [5:0]  err_in;
  logic [5:0]  clr_mask;
  logic [5:0]  flags;
  logic [2:0]  first_idx;
  logic        first_vld;
  logic        led;
`ifdef FAULT_CNT_EN
  logic [2:0]  cnt_sel;
  logic [7:0]  cnt;
`endif

  always #5 clk = ~clk;

  fault_blink_encoder #(
    .NUM_CH(NUM_CH), .DIV(DIV), .ON_TICKS(ON_T), .OFF_TICKS(OFF_T), .GAP_TICKS(GAP_T)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .ena       (ena),
    .err_in    (err_in),
    .clr_mask  (clr_mask),
    .flags     (flags),
    .first_idx (first_idx),
    .first_vld (first_vld),
    .led       (led)
`ifdef FAULT_CNT_EN
    ,
    .cnt_sel   (cnt_sel),
    .cnt       (cnt)
`endif
  );

  typedef struct {
    logic [5:0] err;
    logic [5:0] clr;
    logic [5:0] flags;
    logic       fvld;
    logic       chk_idx;
    logic [2:0] fidx;
  } vec_t;

  typedef struct {
    logic [5:0] flags;
    logic       fvld;
    logic       chk_idx;
    logic [2:0] fidx;
  } exp_t;

  typedef struct {
    logic lvl;
    int   len;
  } run_t;

  vec_t vecs [12];
  exp_t exp_q [$];
  run_t run_q [$];

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic push_run(input logic lvl, input int len);
    run_t r;
    r.lvl = lvl;
    r.len = len;
    run_q.push_back(r);
  endtask

  // Returns at the first negedge with led high, or after 'bound' negedges.
  task automatic wait_led(input int bound, output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (led !== 1'b1 && n < bound);
  endtask

  // Measures completed LED runs from the current sample and pops one
  // expected run per level change until the queue is drained.
  task automatic check_runs(input string tag);
    logic lvl;
    int   len;
    int   budget;
    run_t e;
    lvl    = led;
    len    = 1;
    budget = 0;
    while (run_q.size() > 0 && budget < 2000) begin
      @(negedge clk);
      budget++;
      if (led === lvl) begin
        len++;
      end else begin
        e = run_q.pop_front();
        chk($sformatf("%s run level", tag), 32'(lvl), 32'(e.lvl));
        chk($sformatf("%s run length lvl=%0d", tag, e.lvl), 32'(len), 32'(e.len));
        lvl = led;
        len = 1;
      end
    end
    if (run_q.size() > 0) begin
      chk($sformatf("%s runs timeout, runs left", tag), 32'(run_q.size()), 32'd0);
      run_q.delete();
    end
  endtask

  task automatic count_led_high(input int cycles, output int highs);
    highs = 0;
    for (int c = 0; c < cycles; c++) begin
      @(negedge clk);
      if (led === 1'b1) highs++;
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    exp_t e;
    int   n;
    int   highs;

    vecs[0]  = '{6'b000100, 6'b000000, 6'b000100, 1'b1, 1'b1, 3'd2};
    vecs[1]  = '{6'b001000, 6'b000000, 6'b001100, 1'b1, 1'b1, 3'd2};
    vecs[2]  = '{6'b000010, 6'b000010, 6'b001110, 1'b1, 1'b1, 3'd2};
    vecs[3]  = '{6'b000000, 6'b000100, 6'b001010, 1'b1, 1'b1, 3'd2};
    vecs[4]  = '{6'b000000, 6'b111111, 6'b000000, 1'b0, 1'b0, 3'd0};
    vecs[5]  = '{6'b001001, 6'b000000, 6'b001001, 1'b1, 1'b1, 3'd0};
    vecs[6]  = '{6'b100000, 6'b000000, 6'b101001, 1'b1, 1'b1, 3'd0};
    vecs[7]  = '{6'b000000, 6'b000001, 6'b101000, 1'b1, 1'b1, 3'd0};
    vecs[8]  = '{6'b010000, 6'b101000, 6'b010000, 1'b1, 1'b1, 3'd0};
    vecs[9]  = '{6'b000000, 6'b010000, 6'b000000, 1'b0, 1'b0, 3'd0};
    vecs[10] = '{6'b110000, 6'b000000, 6'b110000, 1'b1, 1'b1, 3'd4};
    vecs[11] = '{6'b000000, 6'b111111, 6'b000000, 1'b0, 1'b0, 3'd0};

    rst      = 1'b1;
    ena      = 1'b0;
    err_in   = '0;
    clr_mask = '0;
`ifdef FAULT_CNT_EN
    cnt_sel  = 3'd5;
`endif
    repeat (3) @(negedge clk);
    chk("reset flags", 32'(flags), 32'd0);
    chk("reset first_vld", 32'(first_vld), 32'd0);
    chk("reset first_idx", 32'(first_idx), 32'd0);
    chk("reset led", 32'(led), 32'd0);
`ifdef FAULT_CNT_EN
    chk("reset cnt", 32'(cnt), 32'd0);
`endif
    rst = 1'b0;

    // Flag table with the LED disabled
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      err_in   = vecs[i].err;
      clr_mask = vecs[i].clr;
      exp_q.push_back('{vecs[i].flags, vecs[i].fvld, vecs[i].chk_idx, vecs[i].fidx});
      @(negedge clk);
      err_in   = '0;
      clr_mask = '0;
      e = exp_q.pop_front();
      chk($sformatf("vec%0d flags", i), 32'(flags), 32'(e.flags));
      chk($sformatf("vec%0d first_vld", i), 32'(first_vld), 32'(e.fvld));
      if (e.chk_idx) chk($sformatf("vec%0d first_idx", i), 32'(first_idx), 32'(e.fidx));
      chk($sformatf("vec%0d led gated", i), 32'(led), 32'd0);
    end

    // Single fault on channel 2
    ena = 1'b1;
    @(negedge clk);
    err_in = 6'b000100;
    @(negedge clk);
    err_in = '0;
    chk("single flags", 32'(flags), 32'b000100);
    chk("single first_idx", 32'(first_idx), 32'd2);
    wait_led(DIV, n);
    chk("single first pulse within DIV", 32'(led === 1'b1 && n <= DIV), 32'd1);
    push_run(1'b1, PH_ON);  push_run(1'b0, PH_OFF);
    push_run(1'b1, PH_ON);  push_run(1'b0, PH_OFF);
    push_run(1'b1, PH_ON);  push_run(1'b0, PH_OFF + PH_GAP);
    push_run(1'b1, PH_ON);  push_run(1'b0, PH_OFF);
    check_runs("single");

    // Reset while the LED is on
    chk("pre-reset led on", 32'(led), 32'd1);
    rst = 1'b1;
    #1;
    chk("async reset led", 32'(led), 32'd0);
    chk("async reset flags", 32'(flags), 32'd0);
    chk("async reset first_vld", 32'(first_vld), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    count_led_high(100, highs);
    chk("after reset no pulses", 32'(highs), 32'd0);

    // Round robin between channels 0 and 3
    @(negedge clk);
    err_in = 6'b001001;
    @(negedge clk);
    err_in = '0;
    chk("rr first_idx", 32'(first_idx), 32'd0);
    chk("rr first_vld", 32'(first_vld), 32'd1);
    wait_led(DIV, n);
    chk("rr first pulse within DIV", 32'(led === 1'b1 && n <= DIV), 32'd1);
    push_run(1'b1, PH_ON);  push_run(1'b0, PH_OFF + PH_GAP);
    for (int p = 0; p < 3; p++) begin
      push_run(1'b1, PH_ON);  push_run(1'b0, PH_OFF);
    end
    push_run(1'b1, PH_ON);  push_run(1'b0, PH_OFF + PH_GAP);
    push_run(1'b1, PH_ON);  push_run(1'b0, PH_OFF + PH_GAP);
    check_runs("rr");

    // Set beats clear, then clear everything while ON
    @(negedge clk);
    err_in   = 6'b000010;
    clr_mask = 6'b000010;
    @(negedge clk);
    err_in   = '0;
    clr_mask = '0;
    chk("set wins flags", 32'(flags), 32'b001011);
    wait_led(300, n);
    chk("led on before clear", 32'(led), 32'd1);
    clr_mask = 6'b111111;
    @(negedge clk);
    clr_mask = '0;
    chk("clear-all led", 32'(led), 32'd0);
    chk("clear-all flags", 32'(flags), 32'd0);
    chk("clear-all first_vld", 32'(first_vld), 32'd0);
    count_led_high(60, highs);
    chk("idle after clear-all", 32'(highs), 32'd0);

    // Enable gating
    ena = 1'b0;
    err_in = 6'b010000;
    @(negedge clk);
    err_in = '0;
    chk("gated flags", 32'(flags), 32'b010000);
    count_led_high(150, highs);
    chk("ena low led quiet", 32'(highs), 32'd0);
    ena = 1'b1;
    wait_led(DIV, n);
    chk("ena high first pulse within DIV", 32'(led === 1'b1 && n <= DIV), 32'd1);
    push_run(1'b1, PH_ON);  push_run(1'b0, PH_OFF);
    check_runs("ena");
    ena = 1'b0;
    @(negedge clk);
    chk("ena drop led", 32'(led), 32'd0);

`ifdef FAULT_CNT_EN
    // Saturating counter on channel 5
    cnt_sel = 3'd5;
    err_in  = 6'b100000;
    for (int k = 1; k <= 300; k++) begin
      @(negedge clk);
      if (k == 10) chk("cnt ramp", 32'(cnt), 32'd9);
    end
    err_in = '0;
    @(negedge clk);
    chk("cnt saturate", 32'(cnt), 32'd255);
    clr_mask = 6'b100000;
    @(negedge clk);
    clr_mask = '0;
    @(negedge clk);
    chk("cnt cleared", 32'(cnt), 32'd0);
    err_in = 6'b100000;
    @(negedge clk);
    err_in  = '0;
    cnt_sel = 3'd7;
    repeat (2) @(negedge clk);
    chk("cnt out-of-range sel", 32'(cnt), 32'd0);
    cnt_sel = 3'd5;
    repeat (2) @(negedge clk);
    chk("cnt after one strobe", 32'(cnt), 32'd1);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
